// File: rtl/regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_op_sequencer
//  Purpose  : Multi-cycle control sequencer for an 8-entry register file
//             (R1-R4, S1-S4). Accepts one command at a time over a
//             valid/ready handshake and drives the file's read selects,
//             function select, write enables and data input for as many
//             cycles as the operation needs (LOAD, CLR, MOV, SWAP, INC/DEC).
//  Ports    : clk, rst_n            - clock, async active-low reset
//             cmd_valid/cmd_ready   - command handshake
//             cmd_op/dst/src/cnt    - command fields
//             cmd_data              - LOAD value
//             rf_out_a              - register file OutA feedback
//             rf_i, out_a_sel, out_b_sel, fun_sel, reg_sel, scr_sel
//                                   - register file control
//             busy, done, err       - status
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_dst,
    input  logic [2:0]  cmd_src,
    input  logic [3:0]  cmd_cnt,
    input  logic [15:0] cmd_data,
    input  logic [15:0] rf_out_a,
    output logic [15:0] rf_i,
    output logic [2:0]  out_a_sel,
    output logic [2:0]  out_b_sel,
    output logic [2:0]  fun_sel,
    output logic [3:0]  reg_sel,
    output logic [3:0]  scr_sel,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_CLR  = 3'b010;
    localparam logic [2:0] c_OP_MOV  = 3'b011;
    localparam logic [2:0] c_OP_SWAP = 3'b100;
    localparam logic [2:0] c_OP_INC  = 3'b101;
    localparam logic [2:0] c_OP_DEC  = 3'b110;

    localparam logic [2:0] c_FUN_DEC  = 3'b000;
    localparam logic [2:0] c_FUN_INC  = 3'b001;
    localparam logic [2:0] c_FUN_LOAD = 3'b010;
    localparam logic [2:0] c_FUN_CLR  = 3'b011;

    localparam logic [2:0] c_ADDR_S4 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_X1   = 3'd1,
        ST_X2   = 3'd2,
        ST_X3   = 3'd3,
        ST_REP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [2:0]  r_dst;
    logic [2:0]  r_src;
    logic [3:0]  r_cnt;
    logic [15:0] r_data;

    logic        w_accept;
    logic        w_rep_cmd;
    logic        w_swap_bad;
    logic        w_wr_en;
    logic [2:0]  w_wr_addr;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    // INC/DEC with a non-zero count go straight to the repeat state;
    // a zero count is rejected through a single X1 cycle instead.
    assign w_rep_cmd  = ((cmd_op == c_OP_INC) || (cmd_op == c_OP_DEC)) && (cmd_cnt != 4'd0);
    // S4 is the swap temporary, so it cannot also be a swap operand.
    assign w_swap_bad = (r_dst == c_ADDR_S4) || (r_src == c_ADDR_S4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= 3'd0;
            r_dst   <= 3'd0;
            r_src   <= 3'd0;
            r_cnt   <= 4'd0;
            r_data  <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_dst  <= cmd_dst;
                r_src  <= cmd_src;
                r_cnt  <= cmd_cnt;
                r_data <= cmd_data;
            end else if (r_state == ST_REP) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_rep_cmd ? ST_REP : ST_X1;
            ST_X1:   w_next = ((r_op == c_OP_SWAP) && !w_swap_bad) ? ST_X2 : ST_IDLE;
            ST_X2:   w_next = ST_X3;
            ST_X3:   w_next = ST_IDLE;
            ST_REP:  if (r_cnt == 4'd1) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_i      = 16'h0000;
        out_a_sel = 3'd0;
        out_b_sel = 3'd0;
        fun_sel   = c_FUN_LOAD;
        done      = 1'b0;
        err       = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = r_dst;
        busy      = (r_state != ST_IDLE);
        cmd_ready = (r_state == ST_IDLE);

        case (r_state)
            ST_X1: begin
                done = 1'b1;
                case (r_op)
                    c_OP_NOP: ;
                    c_OP_LOAD: begin
                        rf_i    = r_data;
                        w_wr_en = 1'b1;
                    end
                    c_OP_CLR: begin
                        fun_sel = c_FUN_CLR;
                        w_wr_en = 1'b1;
                    end
                    c_OP_MOV: begin
                        out_a_sel = r_src;
                        rf_i      = rf_out_a;
                        w_wr_en   = 1'b1;
                    end
                    c_OP_SWAP: begin
                        if (w_swap_bad) begin
                            err = 1'b1;
                        end else begin
                            done      = 1'b0;
                            out_a_sel = r_dst;
                            rf_i      = rf_out_a;
                            w_wr_en   = 1'b1;
                            w_wr_addr = c_ADDR_S4;
                        end
                    end
                    // INC/DEC only reach X1 with a zero count; op 111 is reserved.
                    default: err = 1'b1;
                endcase
            end
            ST_X2: begin
                out_a_sel = r_src;
                rf_i      = rf_out_a;
                w_wr_en   = 1'b1;
            end
            ST_X3: begin
                out_a_sel = c_ADDR_S4;
                rf_i      = rf_out_a;
                w_wr_en   = 1'b1;
                w_wr_addr = r_src;
                done      = 1'b1;
            end
            ST_REP: begin
                fun_sel = (r_op == c_OP_INC) ? c_FUN_INC : c_FUN_DEC;
                w_wr_en = 1'b1;
                done    = (r_cnt == 4'd1);
            end
            default: ;
        endcase
    end

    // Active-low one-cold write decode: bit 3 selects R1/S1, bit 0 R4/S4.
    always_comb begin
        reg_sel = 4'b1111;
        scr_sel = 4'b1111;
        if (w_wr_en) begin
            if (!w_wr_addr[2]) reg_sel[2'd3 - w_wr_addr[1:0]] = 1'b0;
            else               scr_sel[2'd3 - w_wr_addr[1:0]] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_op_sequencer
//  Purpose  : Self-checking bench for regfile_op_sequencer. A small register
//             file model reacts to the sequencer's controls; an abstract
//             command-level model predicts register contents, cycle counts
//             and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_dst, cmd_src;
    logic [3:0]  cmd_cnt;
    logic [15:0] cmd_data;
    logic [15:0] rf_out_a;
    logic [15:0] rf_i;
    logic [2:0]  out_a_sel, out_b_sel, fun_sel;
    logic [3:0]  reg_sel, scr_sel;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_cnt(cmd_cnt),
        .cmd_data(cmd_data), .rf_out_a(rf_out_a), .rf_i(rf_i),
        .out_a_sel(out_a_sel), .out_b_sel(out_b_sel), .fun_sel(fun_sel),
        .reg_sel(reg_sel), .scr_sel(scr_sel), .busy(busy), .done(done), .err(err)
    );

    // Register file being controlled.
    logic [15:0] rf [8] = '{default: 16'h0000};
    assign rf_out_a = rf[out_a_sel];

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if ((i < 4) ? !reg_sel[3-i] : !scr_sel[7-i]) begin
                case (fun_sel)
                    3'b000:  rf[i] <= rf[i] - 16'd1;
                    3'b001:  rf[i] <= rf[i] + 16'd1;
                    3'b010:  rf[i] <= rf_i;
                    default: rf[i] <= 16'h0000;
                endcase
            end
        end
    end

    // Command-level expectation of the register contents.
    logic [15:0] m [8] = '{default: 16'h0000};

    // Per-cycle observations of the most recent command.
    logic [3:0] seen_reg [16];
    logic [3:0] seen_scr [16];
    logic [2:0] seen_fun [16];
    logic [2:0] seen_outa [16];

    // Fields presented while a held command waits for acceptance.
    logic [2:0]  h_op, h_dst, h_src;
    logic [3:0]  h_cnt;
    logic [15:0] h_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_rf();
        logic [127:0] p;
        for (int i = 0; i < 8; i++) p[i*16 +: 16] = rf[i];
        return p;
    endfunction

    function automatic logic [127:0] pack_m();
        logic [127:0] p;
        for (int i = 0; i < 8; i++) p[i*16 +: 16] = m[i];
        return p;
    endfunction

    task automatic model_apply(input logic [2:0] op, dst, src, input logic [3:0] cnt,
                               input logic [15:0] data, output int cyc, output bit e);
        logic [15:0] ta, tb;
        cyc = 1;
        e   = 1'b0;
        case (op)
            3'd1: m[dst] = data;
            3'd2: m[dst] = 16'h0000;
            3'd3: m[dst] = m[src];
            3'd4: begin
                if (dst == 3'd7 || src == 3'd7) e = 1'b1;
                else begin
                    ta = m[dst]; tb = m[src];
                    m[7] = ta; m[dst] = tb; m[src] = ta;
                    cyc = 3;
                end
            end
            3'd5, 3'd6: begin
                if (cnt == 4'd0) e = 1'b1;
                else begin
                    m[dst] = (op == 3'd5) ? m[dst] + 16'(cnt) : m[dst] - 16'(cnt);
                    cyc = int'(cnt);
                end
            end
            3'd7: e = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_cmd(input logic [2:0] op, dst, src, input logic [3:0] cnt,
                           input logic [15:0] data, input bit hold);
        int  exp_cyc, n, budget;
        bit  exp_err, got_err, got_done;
        int  nz;
        model_apply(op, dst, src, cnt, data, exp_cyc, exp_err);
        budget = 0;
        while (!cmd_ready && budget < 20) begin
            @(posedge clk); #1; budget++;
        end
        check("ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_cnt = cnt; cmd_data = data;
        @(posedge clk); #1;
        if (hold) begin
            cmd_op = h_op; cmd_dst = h_dst; cmd_src = h_src; cmd_cnt = h_cnt; cmd_data = h_data;
        end else begin
            cmd_valid = 1'b0;
            cmd_op = 3'($urandom); cmd_dst = 3'($urandom); cmd_src = 3'($urandom);
            cmd_cnt = 4'($urandom); cmd_data = 16'($urandom);
        end
        n = 0; got_done = 1'b0; got_err = 1'b0;
        while (n < 16) begin
            seen_reg[n] = reg_sel; seen_scr[n] = scr_sel;
            seen_fun[n] = fun_sel; seen_outa[n] = out_a_sel;
            nz = 0;
            for (int b = 0; b < 4; b++) nz += (!reg_sel[b] ? 1 : 0) + (!scr_sel[b] ? 1 : 0);
            check("cycle_ctl", {busy, err & ~done, nz > 1, cmd_ready}, 4'b1000);
            n++;
            if (done) begin
                got_done = 1'b1; got_err = err;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_seen", got_done, 1'b1);
        check("cycles", n, exp_cyc);
        check("err", got_err, exp_err);
        @(posedge clk); #1;
        check("idle_after", {cmd_ready, busy, done}, 3'b100);
        check("regs", pack_rf(), pack_m());
    endtask

    initial begin
        int  ec;
        bit  ee;
        logic [15:0] olda, oldb;
        logic [2:0]  ro, rd, rs;

        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_cnt = 4'd0; cmd_data = 16'h0;
        h_op = 3'd0; h_dst = 3'd0; h_src = 3'd0; h_cnt = 4'd0; h_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {reg_sel, scr_sel, cmd_ready, busy, done, err, fun_sel, out_a_sel, out_b_sel, rf_i},
              {4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'd0, 3'd0, 16'h0000});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // LOAD R2 then MOV S3 <- R2
        run_cmd(3'd1, 3'd1, 3'd0, 4'd0, 16'hA5A5, 1'b0);
        check("load_wen", {seen_reg[0], seen_scr[0]}, {4'b1011, 4'b1111});
        run_cmd(3'd3, 3'd6, 3'd1, 4'd0, 16'h0, 1'b0);
        check("mov_ctl", {seen_outa[0], seen_reg[0], seen_scr[0]}, {3'd1, 4'b1111, 4'b1101});
        check("mov_s3", rf[6], 16'hA5A5);

        // SWAP R1 <-> R4
        run_cmd(3'd1, 3'd0, 3'd0, 4'd0, 16'h1111, 1'b0);
        run_cmd(3'd1, 3'd3, 3'd0, 4'd0, 16'h4444, 1'b0);
        run_cmd(3'd4, 3'd0, 3'd3, 4'd0, 16'h0, 1'b0);
        check("swap_wen", {seen_reg[0], seen_scr[0], seen_reg[1], seen_scr[1], seen_reg[2], seen_scr[2]},
              {4'b1111, 4'b1110, 4'b0111, 4'b1111, 4'b1110, 4'b1111});
        check("swap_val", {rf[0], rf[3], rf[7]}, {16'h4444, 16'h1111, 16'h1111});

        // INC R3 x5 from FFFE, DEC S1 x1 from 0
        run_cmd(3'd1, 3'd2, 3'd0, 4'd0, 16'hFFFE, 1'b0);
        run_cmd(3'd5, 3'd2, 3'd0, 4'd5, 16'h0, 1'b0);
        check("inc_ctl", {seen_fun[0], seen_reg[0], seen_fun[4], seen_reg[4]},
              {3'b001, 4'b1101, 3'b001, 4'b1101});
        check("inc_val", rf[2], 16'h0003);
        run_cmd(3'd2, 3'd4, 3'd0, 4'd0, 16'h0, 1'b0);
        run_cmd(3'd6, 3'd4, 3'd0, 4'd1, 16'h0, 1'b0);
        check("dec_val", rf[4], 16'hFFFF);

        // Rejected commands: no writes at all
        run_cmd(3'd4, 3'd1, 3'd7, 4'd0, 16'h0, 1'b0);
        check("swap7_wen", {seen_reg[0], seen_scr[0]}, 8'hFF);
        run_cmd(3'd5, 3'd1, 3'd0, 4'd0, 16'h0, 1'b0);
        check("inc0_wen", {seen_reg[0], seen_scr[0]}, 8'hFF);
        run_cmd(3'd7, 3'd1, 3'd2, 4'd3, 16'h1234, 1'b0);
        check("op7_wen", {seen_reg[0], seen_scr[0]}, 8'hFF);

        // Held LOAD while a 15-count DEC runs
        h_op = 3'd1; h_dst = 3'd0; h_src = 3'd0; h_cnt = 4'd0; h_data = 16'hBEEF;
        run_cmd(3'd6, 3'd0, 3'd0, 4'd15, 16'h0, 1'b1);
        check("hold_dec", rf[0], 16'h4444 - 16'd15);
        run_cmd(3'd1, 3'd0, 3'd0, 4'd0, 16'hBEEF, 1'b0);

        // Reset during SWAP X2
        olda = rf[1]; oldb = rf[2];
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_dst = 3'd1; cmd_src = 3'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("swap_x2", {busy, out_a_sel}, {1'b1, 3'd2});
        rst_n = 1'b0;
        #1;
        check("abort_out", {reg_sel, scr_sel, busy, cmd_ready, done, err},
              {4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("abort_rf", {rf[1], rf[2], rf[7]}, {olda, oldb, olda});
        m[7] = olda;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized commands against the model
        for (int i = 0; i < 8; i++) run_cmd(3'd1, 3'(i), 3'd0, 4'd0, 16'($urandom), 1'b0);
        for (int k = 0; k < 150; k++) begin
            ro = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
            run_cmd(ro, rd, rs, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0);
        end
        model_apply(3'd0, 3'd0, 3'd0, 4'd0, 16'h0, ec, ee);
        check("nop_model", {ec, ee}, {32'd1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
